atetris_rom_loader: RTL
=======================

# atetris_rom_loader

Sequences the ROM download path of the Atari Tetris core. Decodes the HPS download byte stream into separate program-ROM and graphics-ROM write ports, and counts accepted bytes against the expected image size. Owns the core reset: the game core is held in reset until a complete, correctly sized image has been loaded and a settle interval has elapsed. Sits between `hps_io` (ioctl signals) and `FPGA_ATETRIS` (ROM write port and reset input).

## Interface
- `PRG_BASE`, 25'h00000, first download address of program ROM
- `PRG_SIZE`, 65536, program ROM bytes (power of two)
- `GFX_BASE`, 25'h10000, first download address of graphics ROM
- `GFX_SIZE`, 65536, graphics ROM bytes (power of two)
- `SETTLE_CYCLES`, 16, core-reset hold after a good load, 1..255

Ports:
- `clk_sys` in 1: single clock; all logic on its rising edge
- `RESET` in 1: synchronous, active-high
- `dl_active` in 1: ioctl_download
- `dl_wr` in 1: ioctl_wr, one-cycle byte strobe
- `dl_addr` in 25: ioctl_addr
- `dl_data` in 8: ioctl_dout
- `wr_addr` out 16: region-relative byte address
- `wr_data` out 8: byte to write
- `prg_we` out 1: program ROM write strobe
- `gfx_we` out 1: graphics ROM write strobe
- `core_reset` out 1: reset to the game core
- `load_ok` out 1: last load complete and correctly sized
- `load_err` out 1: last load short, long or out of range

## Operation
- States: WAIT_ROM, LOAD, SETTLE, RUN.
- Reset values: state WAIT_ROM, byte count 0, settle count 0, `prg_we`/`gfx_we` 0, `wr_addr`/`wr_data` 0, `core_reset` 1, `load_ok` 0, `load_err` 0.
- WAIT_ROM: `core_reset`=1. `dl_active`=1 moves to LOAD.
- Entering LOAD clears the byte count, `load_ok` and `load_err`.
- LOAD:
  - A strobe is accepted only when `dl_wr` and `dl_active` are both 1.
  - Address inside [PRG_BASE, PRG_BASE+PRG_SIZE) pulses `prg_we`, with `wr_addr` = dl_addr−PRG_BASE.
  - Address inside the GFX window pulses `gfx_we`, with `wr_addr` = dl_addr−GFX_BASE.
  - Address outside both windows: the byte is dropped, no strobe, and a sticky `oor` flag is set.
  - Every accepted in-range byte increments the 18-bit count, which saturates at 2^18−1.
- When `dl_active` falls in LOAD:
  - If count == PRG_SIZE+GFX_SIZE and `oor`=0: set `load_ok`=1 and go to SETTLE.
  - Otherwise: set `load_err`=1 and go to WAIT_ROM.
- SETTLE: `core_reset`=1 and the counter counts up to SETTLE_CYCLES, then the block goes to RUN.
- RUN: `core_reset`=0. If `dl_active` rises (reload), the block goes to LOAD and `core_reset` is reasserted in the same cycle as the transition.
- `dl_active` rising during SETTLE: go to LOAD and abandon the settle interval.
- A `dl_wr` in the same cycle as the `dl_active` rising edge is accepted.
- A strobe in the same cycle as the `dl_active` falling edge is ignored.
- Duplicate addresses are counted twice. No address-order check is made.
- `RESET` mid-load: return to reset values. If `dl_active` is still 1, LOAD is re-entered next cycle with count 0, so that load ends in `load_err`.
- `RESET` dominates every other input.

## Timing
- Write path is registered: `dl_wr` at cycle N gives `prg_we`/`gfx_we`, `wr_addr` and `wr_data` valid at cycle N+1 for exactly one cycle.
- Back-to-back strobes on consecutive cycles are supported with no stall.
- `dl_active` falling at cycle N gives `load_ok`/`load_err` and the state change at N+1.
- `core_reset` falls exactly SETTLE_CYCLES+1 cycles after `load_ok` rises.
- `core_reset` is registered; it is 1 in every cycle where the state is not RUN.

## Structure
- Package `atetris_rom_pkg` holds:
  - state enum `loader_state_t` {WAIT_ROM, LOAD, SETTLE, RUN};
  - region enum `rom_region_t` {RGN_NONE, RGN_PRG, RGN_GFX};
  - the default base/size constants.
- Sub-module `atetris_rom_region_decode` is combinational: it takes `dl_addr` and returns the region and relative address.
- The state machine, counters and output registers live in the top module.

## Test plan
- Good load: 131072 sequential writes from 0. Expect 65536 `prg_we` pulses (addresses 0..FFFF) and 65536 `gfx_we` pulses with `wr_addr` restarting at 0 at dl_addr 0x10000. After `dl_active` falls, `load_ok`=1, and `core_reset` drops 17 cycles later.
- Short load: 131071 bytes then `dl_active` falls. Expect `load_err`=1, `load_ok`=0, state WAIT_ROM and `core_reset` held at 1.
- Out of range: a full image plus one write at 0x20000. Expect no strobe for 0x20000 and `load_err`=1 at the end.
- Reload in RUN: after a good load, raise `dl_active`. Expect `core_reset`=1 on the next edge and `load_ok` cleared; a second good load returns the block to RUN.
- Reset mid-load: assert `RESET` for one cycle after 1000 bytes while `dl_active` stays 1. Expect the count restarted and `load_err`=1 at the end of the download.
- Edge strobes: a write in the same cycle as the `dl_active` rising edge produces a strobe; a write in the same cycle as the falling edge produces no strobe.

Source files
------------

// File: rtl/atetris_rom_pkg.sv
// -----------------------------------------------------------------------------
// atetris_rom_pkg
// Shared types and default constants for the Atari Tetris ROM download path.
//   loader_state_t : sequencer states of atetris_rom_loader
//   rom_region_t   : which ROM a download address falls into
//   DEF_*          : default download windows, image size and settle interval
// -----------------------------------------------------------------------------
package atetris_rom_pkg;

    typedef enum logic [1:0] {
        WAIT_ROM,
        LOAD,
        SETTLE,
        RUN
    } loader_state_t;

    typedef enum logic [1:0] {
        RGN_NONE,
        RGN_PRG,
        RGN_GFX
    } rom_region_t;

    localparam int          ADDR_W            = 25;
    localparam int          REL_W             = 16;
    localparam int          COUNT_W           = 18;
    localparam int          SETTLE_W          = 8;

    localparam logic [24:0] DEF_PRG_BASE      = 25'h00000;
    localparam int          DEF_PRG_SIZE      = 65536;
    localparam logic [24:0] DEF_GFX_BASE      = 25'h10000;
    localparam int          DEF_GFX_SIZE      = 65536;
    localparam int          DEF_SETTLE_CYCLES = 16;

endpackage

// File: rtl/atetris_rom_region_decode.sv
// -----------------------------------------------------------------------------
// atetris_rom_region_decode
// Combinational address decoder: classifies a download address into the
// program-ROM window, the graphics-ROM window or neither, and produces the
// byte address relative to the start of the matching window.
// Ports:
//   dl_addr  in  25 : download byte address
//   region   out    : RGN_PRG / RGN_GFX / RGN_NONE
//   rel_addr out 16 : dl_addr minus the matching window base (0 for RGN_NONE)
// -----------------------------------------------------------------------------
module atetris_rom_region_decode
    import atetris_rom_pkg::*;
#(
    parameter logic [24:0] PRG_BASE = DEF_PRG_BASE,
    parameter int          PRG_SIZE = DEF_PRG_SIZE,
    parameter logic [24:0] GFX_BASE = DEF_GFX_BASE,
    parameter int          GFX_SIZE = DEF_GFX_SIZE
) (
    input  logic [ADDR_W-1:0] dl_addr,
    output rom_region_t       region,
    output logic [REL_W-1:0]  rel_addr
);

    localparam int N_WIN = 2;   // window 0 = program ROM, window 1 = graphics ROM

    logic [N_WIN-1:0] win_hit;
    logic [REL_W-1:0] win_rel [N_WIN];

    generate
        for (genvar gi = 0; gi < N_WIN; gi++) begin : g_win
            localparam logic [24:0] BASE = (gi == 0) ? PRG_BASE : GFX_BASE;
            localparam int          SIZE = (gi == 0) ? PRG_SIZE : GFX_SIZE;
            // One extra bit so that BASE+SIZE cannot wrap at the top of the
            // 25-bit address space.
            localparam logic [25:0] LO   = {1'b0, BASE};
            localparam logic [25:0] HI   = LO + 26'(SIZE);

            logic [25:0] addr_ext;
            assign addr_ext     = {1'b0, dl_addr};
            assign win_hit[gi]  = (addr_ext >= LO) && (addr_ext < HI);
            // Windows are at most 64 KiB, so the offset is exact modulo 2^16.
            assign win_rel[gi]  = dl_addr[REL_W-1:0] - BASE[REL_W-1:0];
        end
    endgenerate

    // Program ROM wins if the windows were ever configured to overlap.
    always_comb begin
        region   = RGN_NONE;
        rel_addr = '0;
        if (win_hit[0]) begin
            region   = RGN_PRG;
            rel_addr = win_rel[0];
        end else if (win_hit[1]) begin
            region   = RGN_GFX;
            rel_addr = win_rel[1];
        end
    end

endmodule

// File: rtl/atetris_rom_loader.sv
// -----------------------------------------------------------------------------
// atetris_rom_loader
// Splits the HPS ioctl download stream into program-ROM and graphics-ROM write
// ports, counts accepted bytes against the expected image size and owns the
// game-core reset: the core stays in reset until a complete, correctly sized
// image has arrived and a settle interval has elapsed.
// Ports:
//   clk_sys    in     : system clock, all logic on its rising edge
//   RESET      in     : synchronous active-high reset
//   dl_active  in     : ioctl_download
//   dl_wr      in     : ioctl_wr, one-cycle byte strobe
//   dl_addr    in  25 : ioctl_addr
//   dl_data    in   8 : ioctl_dout
//   wr_addr    out 16 : region-relative byte address (registered)
//   wr_data    out  8 : byte to write (registered)
//   prg_we     out    : program ROM write strobe, one cycle per byte
//   gfx_we     out    : graphics ROM write strobe, one cycle per byte
//   core_reset out    : reset to the game core, low only in RUN
//   load_ok    out    : last load complete and correctly sized
//   load_err   out    : last load short, long or out of range
// -----------------------------------------------------------------------------
module atetris_rom_loader
    import atetris_rom_pkg::*;
#(
    parameter logic [24:0] PRG_BASE      = DEF_PRG_BASE,
    parameter int          PRG_SIZE      = DEF_PRG_SIZE,
    parameter logic [24:0] GFX_BASE      = DEF_GFX_BASE,
    parameter int          GFX_SIZE      = DEF_GFX_SIZE,
    parameter int          SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic [REL_W-1:0]  wr_addr,
    output logic [7:0]        wr_data,
    output logic              prg_we,
    output logic              gfx_we,
    output logic              core_reset,
    output logic              load_ok,
    output logic              load_err
);

    localparam logic [COUNT_W-1:0]  IMAGE_BYTES = COUNT_W'(PRG_SIZE + GFX_SIZE);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);

    loader_state_t       state_reg;
    logic [COUNT_W-1:0]  count_reg;
    logic [SETTLE_W-1:0] settle_reg;
    logic                oor_reg;
    logic [REL_W-1:0]    wr_addr_reg;
    logic [7:0]          wr_data_reg;
    logic                prg_we_reg;
    logic                gfx_we_reg;
    logic                core_reset_reg;
    logic                load_ok_reg;
    logic                load_err_reg;

    rom_region_t         region;
    logic [REL_W-1:0]    rel_addr;
    logic                byte_accept;
    logic                byte_hit;
    logic                byte_oor;

    atetris_rom_region_decode #(
        .PRG_BASE (PRG_BASE),
        .PRG_SIZE (PRG_SIZE),
        .GFX_BASE (GFX_BASE),
        .GFX_SIZE (GFX_SIZE)
    ) u_decode (
        .dl_addr  (dl_addr),
        .region   (region),
        .rel_addr (rel_addr)
    );

    // A strobe only counts while the download is active. Outside LOAD an
    // active download always moves the FSM into LOAD on the same edge, so a
    // strobe coinciding with the rising edge of dl_active is still taken,
    // while one coinciding with the falling edge is not.
    assign byte_accept = dl_active && dl_wr;
    assign byte_hit    = byte_accept && (region != RGN_NONE);
    assign byte_oor    = byte_accept && (region == RGN_NONE);

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_reg      <= WAIT_ROM;
            count_reg      <= '0;
            settle_reg     <= '0;
            oor_reg        <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            prg_we_reg     <= 1'b0;
            gfx_we_reg     <= 1'b0;
            core_reset_reg <= 1'b1;
            load_ok_reg    <= 1'b0;
            load_err_reg   <= 1'b0;
        end else begin
            // Write port: one-cycle strobes, address/data hold between bytes.
            prg_we_reg <= 1'b0;
            gfx_we_reg <= 1'b0;
            if (byte_hit) begin
                wr_addr_reg <= rel_addr;
                wr_data_reg <= dl_data;
                prg_we_reg  <= (region == RGN_PRG);
                gfx_we_reg  <= (region == RGN_GFX);
            end

            if (state_reg != LOAD && dl_active) begin
                // Start (or restart) a download from any other state. The
                // byte count starts with this cycle's byte, if any.
                state_reg      <= LOAD;
                count_reg      <= byte_hit ? COUNT_W'(1) : '0;
                oor_reg        <= byte_oor;
                settle_reg     <= '0;
                load_ok_reg    <= 1'b0;
                load_err_reg   <= 1'b0;
                core_reset_reg <= 1'b1;
            end else begin
                case (state_reg)
                    WAIT_ROM: begin
                        core_reset_reg <= 1'b1;
                    end

                    LOAD: begin
                        if (dl_active) begin
                            if (byte_hit && (count_reg != '1)) begin
                                count_reg <= count_reg + COUNT_W'(1);
                            end
                            if (byte_oor) begin
                                oor_reg <= 1'b1;
                            end
                        end else if ((count_reg == IMAGE_BYTES) && !oor_reg) begin
                            state_reg   <= SETTLE;
                            settle_reg  <= '0;
                            load_ok_reg <= 1'b1;
                        end else begin
                            state_reg    <= WAIT_ROM;
                            load_err_reg <= 1'b1;
                        end
                    end

                    SETTLE: begin
                        // Release happens SETTLE_CYCLES+1 edges after load_ok.
                        if (settle_reg == SETTLE_LAST) begin
                            state_reg      <= RUN;
                            core_reset_reg <= 1'b0;
                        end else begin
                            settle_reg <= settle_reg + SETTLE_W'(1);
                        end
                    end

                    RUN: begin
                        core_reset_reg <= 1'b0;
                    end

                    default: begin
                        state_reg      <= WAIT_ROM;
                        core_reset_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign prg_we     = prg_we_reg;
    assign gfx_we     = gfx_we_reg;
    assign core_reset = core_reset_reg;
    assign load_ok    = load_ok_reg;
    assign load_err   = load_err_reg;

endmodule
